// File: rtl/tawas_au_mt.sv
// Multi-slice Tawas arithmetic unit: one register stage, per-slice immediate prefix and flags.
// Optional iterative radix-4 multiplier (op 06) is enabled by defining TAWAS_AU_MUL_EN.
module tawas_au_mt #(
  parameter int DW     = 32,
  parameter int NSLICE = 2,
  parameter int SW     = $clog2(NSLICE)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [SW-1:0] SLICE,
  output logic [7:0]    AU_FLAGS,
  input  logic          AU_OP_VLD,
  input  logic [14:0]   AU_OP,
  input  logic          AU_IMM_VLD,
  input  logic [DW-5:0] AU_IMM,
  output logic [2:0]    AU_RA_SEL,
  input  logic [DW-1:0] AU_RA,
  output logic [2:0]    AU_RB_SEL,
  input  logic [DW-1:0] AU_RB,
  output logic          AU_BUSY,
  output logic          AU_RC_VLD,
  output logic [2:0]    AU_RC_SEL,
  output logic [DW-1:0] AU_RC
);

  localparam logic [4:0] OP_OR  = 5'h00, OP_XOR = 5'h01, OP_CMP = 5'h02, OP_ADD = 5'h03;
  localparam logic [4:0] OP_SUB = 5'h04, OP_AND = 5'h05, OP_MUL = 5'h06;
  localparam logic [4:0] OP_BSET = 5'h18, OP_BCLR = 5'h19, OP_DECN = 5'h1A, OP_INCN = 5'h1B;
  localparam logic [4:0] OP_SHL = 5'h1C, OP_SHR = 5'h1D, OP_SAR = 5'h1E, OP_SEXT = 5'h1F;

  function automatic logic [DW-1:0] sign_ext(input logic [DW-1:0] v, input logic [1:0] sel);
    logic [DW-1:0] r;
    int k;
    r = v;
    k = 8 * int'(sel) - 1;
    if (sel != 2'd0 && k < DW) begin
      for (int i = 0; i < DW; i++) begin
        if (i > k) r[i] = v[k];
      end
    end
    return r;
  endfunction

  logic [DW-5:0] imm_hold_q [NSLICE];
  logic [DW-5:0] imm_hold_d [NSLICE];
  logic [7:0]    flags_q    [NSLICE];
  logic [7:0]    flags_d    [NSLICE];

  logic          vld_q, vld_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]    n_q, n_d;
  logic [4:0]    op_q, op_d;
  logic [2:0]    rc_q, rc_d;
  logic [SW-1:0] slice_q, slice_d;

  logic          busy, done, issue, stage_live;
  logic [DW-1:0] mul_res;
  logic [2:0]    mul_rc;
  logic [SW-1:0] mul_slice;

  logic [DW-1:0] imm_val, b_in, result, bit_m;
  logic [4:0]    op_in;
  logic signed [DW:0] a_x, b_x, sum;
  logic          addsub, ovf, cy;
  logic [7:0]    new_flags;

  assign AU_RA_SEL = AU_OP[8:6];
  assign AU_RB_SEL = AU_OP[5:3];
  assign AU_FLAGS  = flags_q[SLICE];
  assign AU_BUSY   = busy;

  // Decode: the prefix read here is the registered one, so a same-cycle prefix load lands on the next op.
  assign imm_val = {imm_hold_q[SLICE], AU_OP[13], AU_OP[5:3]};
  assign b_in    = AU_OP[14] ? imm_val : AU_RB;
  assign op_in   = AU_OP[14] ? {1'b0, AU_OP[12:9]} : AU_OP[13:9];
  assign issue   = AU_OP_VLD && !busy;

  always_comb begin
    vld_d   = issue;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    op_d    = op_q;
    rc_d    = rc_q;
    slice_d = slice_q;
    if (issue) begin
      a_d     = AU_RA;
      b_d     = b_in;
      n_d     = {1'b0, AU_OP[5:3]} + 4'd1;
      op_d    = op_in;
      rc_d    = AU_OP[2:0];
      slice_d = SLICE;
    end
  end

  always_comb begin
    imm_hold_d = imm_hold_q;
    if (AU_IMM_VLD) imm_hold_d[SLICE] = AU_IMM;
  end

  // Execute: combinational from the stage register.
  always_comb begin
    a_x    = {a_q[DW-1], a_q};
    b_x    = {b_q[DW-1], b_q};
    sum    = (op_q == OP_SUB || op_q == OP_CMP) ? (a_x - b_x) : (a_x + b_x);
    bit_m  = DW'(1) << (n_q - 4'd1);
    result = '0;
    case (op_q)
      OP_OR:                  result = a_q | b_q;
      OP_XOR:                 result = a_q ^ b_q;
      OP_CMP, OP_ADD, OP_SUB: result = sum[DW-1:0];
      OP_AND:                 result = a_q & b_q;
      OP_BSET:                result = a_q | bit_m;
      OP_BCLR:                result = a_q & ~bit_m;
      OP_DECN:                result = a_q - DW'(n_q);
      OP_INCN:                result = a_q + DW'(n_q);
      OP_SHL:                 result = a_q << n_q;
      OP_SHR:                 result = a_q >> n_q;
      OP_SAR:                 result = $signed(a_q) >>> n_q;
      OP_SEXT:                result = sign_ext(a_q, n_q[1:0]);
      default:                result = '0;
    endcase
    addsub = (op_q == OP_CMP || op_q == OP_ADD || op_q == OP_SUB);
    ovf    = addsub && (sum[DW] ^ sum[DW-1]);
    // Sign-extended adder: unsigned carry-out is recovered from the extra sum bit.
    cy     = addsub && ((op_q == OP_ADD) ? (sum[DW] ^ a_q[DW-1] ^ b_q[DW-1]) : (a_q < b_q));
    new_flags = {4'b0000, cy, ovf, result[DW-1], (result == '0)};
  end

  always_comb begin
    flags_d = flags_q;
    if (stage_live) flags_d[slice_q] = new_flags;
    if (done) flags_d[mul_slice] = {6'b0, mul_res[DW-1], (mul_res == '0)};
  end

  assign AU_RC_VLD = (stage_live && op_q != OP_CMP) || done;
  assign AU_RC_SEL = done ? mul_rc : rc_q;
  assign AU_RC     = done ? mul_res : result;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NSLICE; i++) begin
        imm_hold_q[i] <= '0;
        flags_q[i]    <= '0;
      end
      vld_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      op_q    <= '0;
      rc_q    <= '0;
      slice_q <= '0;
    end else begin
      imm_hold_q <= imm_hold_d;
      flags_q    <= flags_d;
      vld_q      <= vld_d;
      a_q        <= a_d;
      b_q        <= b_d;
      n_q        <= n_d;
      op_q       <= op_d;
      rc_q       <= rc_d;
      slice_q    <= slice_d;
    end
  end

`ifdef TAWAS_AU_MUL_EN
  localparam int CW = $clog2(DW);

  logic          busy_q, busy_d, done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] ma_q, ma_d, mb_q, mb_d, acc_q, acc_d, pp;
  logic [2:0]    mrc_q, mrc_d;
  logic [SW-1:0] msl_q, msl_d;

  assign busy       = busy_q;
  assign done       = done_q;
  assign mul_res    = acc_q;
  assign mul_rc     = mrc_q;
  assign mul_slice  = msl_q;
  assign stage_live = vld_q && (op_q != OP_MUL);

  // Radix-4: retire two multiplier bits per busy cycle, DW/2 cycles in total.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    ma_d   = ma_q;
    mb_d   = mb_q;
    acc_d  = acc_q;
    mrc_d  = mrc_q;
    msl_d  = msl_q;
    case (mb_q[1:0])
      2'd0:    pp = '0;
      2'd1:    pp = ma_q;
      2'd2:    pp = ma_q << 1;
      default: pp = ma_q + (ma_q << 1);
    endcase
    if (issue && op_in == OP_MUL) begin
      busy_d = 1'b1;
      cnt_d  = CW'(DW / 2 - 1);
      ma_d   = AU_RA;
      mb_d   = b_in;
      acc_d  = '0;
      mrc_d  = AU_OP[2:0];
      msl_d  = SLICE;
    end else if (busy_q) begin
      acc_d = acc_q + pp;
      ma_d  = ma_q << 2;
      mb_d  = mb_q >> 2;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      ma_q   <= '0;
      mb_q   <= '0;
      acc_q  <= '0;
      mrc_q  <= '0;
      msl_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      ma_q   <= ma_d;
      mb_q   <= mb_d;
      acc_q  <= acc_d;
      mrc_q  <= mrc_d;
      msl_q  <= msl_d;
    end
  end

  always @(posedge CLK) begin
    if (!RST) assert (!(AU_OP_VLD && busy_q)) else $error("tawas_au_mt: op issued while multiplier busy");
  end
`else
  assign busy       = 1'b0;
  assign done       = 1'b0;
  assign mul_res    = '0;
  assign mul_rc     = '0;
  assign mul_slice  = '0;
  assign stage_live = vld_q;
`endif

endmodule
